// File: rtl/alu_status_stage.sv
// Execute-to-memory slot behind the ALU: registers the result, keeps the Z/N
// status register and resolves flag-based branches. Optional BR_STATS_EN adds branch counters.
module alu_status_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_zout,
    input  logic              alu_nout,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    input  logic              in_setflags,
    input  logic [2:0]        in_brcond,
    input  logic [DATA_W-1:0] in_brtarget,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_regwrite,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              status_z,
    output logic              status_n
`ifdef BR_STATS_EN
    ,
    output logic [15:0]       br_count,
    output logic [15:0]       br_taken_count
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on valid, and flush kills the
    // incoming instruction as well as the slot.
    logic              slot_valid;
    logic [DATA_W-1:0] slot_sum;
    logic [RD_W-1:0]   slot_rd;
    logic              slot_regwrite;
    logic              slot_taken;
    logic [DATA_W-1:0] slot_target;
    logic              stat_z;
    logic              stat_n;

    logic capture;
    logic drain;
    logic eff_z;
    logic eff_n;
    logic cond_true;

    assign in_ready = ~slot_valid | out_ready;
    assign capture  = in_valid & in_ready & ~flush;
    assign drain    = slot_valid & out_ready;

    // A flag-setting instruction branches on its own fresh flags.
    assign eff_z = in_setflags ? alu_zout : stat_z;
    assign eff_n = in_setflags ? alu_nout : stat_n;

    always_comb begin
        cond_true = 1'b0;
        case (in_brcond)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = eff_z;
            3'b010:  cond_true = ~eff_z;
            3'b011:  cond_true = eff_n;
            3'b100:  cond_true = ~eff_n;
            3'b101:  cond_true = eff_z | eff_n;
            3'b110:  cond_true = ~eff_z & ~eff_n;
            default: cond_true = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid    <= 1'b0;
            slot_sum      <= '0;
            slot_rd       <= '0;
            slot_regwrite <= 1'b0;
            slot_taken    <= 1'b0;
            slot_target   <= '0;
            stat_z        <= 1'b0;
            stat_n        <= 1'b0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (capture) begin
            slot_valid    <= 1'b1;
            slot_sum      <= alu_sum;
            slot_rd       <= in_rd;
            slot_regwrite <= in_regwrite;
            slot_taken    <= cond_true;
            slot_target   <= in_brtarget;
            if (in_setflags) begin
                stat_z <= alu_zout;
                stat_n <= alu_nout;
            end
        end else if (drain) begin
            slot_valid <= 1'b0;
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count       <= 16'h0000;
            br_taken_count <= 16'h0000;
        end else if (capture) begin
            if (in_brcond != 3'b000 && br_count != 16'hFFFF)
                br_count <= br_count + 16'h0001;
            if (cond_true && br_taken_count != 16'hFFFF)
                br_taken_count <= br_taken_count + 16'h0001;
        end
    end
`endif

    assign out_valid    = slot_valid;
    assign out_sum      = slot_sum;
    assign out_rd       = slot_rd;
    assign out_regwrite = slot_valid & slot_regwrite;
    assign br_taken     = slot_valid & slot_taken;
    assign br_target    = slot_target;
    assign status_z     = stat_z;
    assign status_n     = stat_n;

endmodule

// File: tb/tb_alu_status_stage.sv
// Directed bench for alu_status_stage with a reference model and an expected
// queue of slot contents; define BR_STATS_EN to also check the branch counters.
module tb_alu_status_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_sum;
    logic        alu_zout;
    logic        alu_nout;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_setflags;
    logic [2:0]  in_brcond;
    logic [31:0] in_brtarget;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        br_taken;
    logic [31:0] br_target;
    logic        status_z;
    logic        status_n;
`ifdef BR_STATS_EN
    logic [15:0] br_count;
    logic [15:0] br_taken_count;
`endif

    always #5 clk = ~clk;

    alu_status_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_nout(alu_nout),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .in_setflags(in_setflags),
        .in_brcond(in_brcond), .in_brtarget(in_brtarget), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_rd(out_rd), .out_regwrite(out_regwrite), .br_taken(br_taken),
        .br_target(br_target), .status_z(status_z), .status_n(status_n)
`ifdef BR_STATS_EN
        , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // expected entry: {sum[31:0], rd[4:0], regwrite, taken, target[31:0]}
    logic [70:0] exp_q[$];
    logic        m_valid, m_z, m_n;
    logic [15:0] m_brc, m_tkc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic eval_cond(input logic [2:0] c, input logic z, input logic n);
        case (c)
            3'd0: return 1'b0;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return z || n;
            3'd6: return !z && !n;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: check outputs at negedge, then advance the model at posedge.
    task automatic tick();
        logic exp_rdy, cap, drn, zf, nf, tk;
        logic [70:0] e;
        @(negedge clk);
        exp_rdy = !m_valid || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_valid);
        chk("status_z", status_z, m_z);
        chk("status_n", status_n, m_n);
`ifdef BR_STATS_EN
        chk("br_count", br_count, m_brc);
        chk("br_taken_count", br_taken_count, m_tkc);
`endif
        if (m_valid) begin
            chk("queue_nonempty", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_sum", out_sum, e[70:39]);
                chk("out_rd", out_rd, e[38:34]);
                chk("out_regwrite", out_regwrite, e[33]);
                chk("br_taken", br_taken, e[32]);
                chk("br_target", br_target, e[31:0]);
            end
        end else begin
            chk("idle_regwrite", out_regwrite, 1'b0);
            chk("idle_br_taken", br_taken, 1'b0);
        end
        cap = rst_n && in_valid && exp_rdy && !flush;
        drn = m_valid && out_ready;
        zf  = in_setflags ? alu_zout : m_z;
        nf  = in_setflags ? alu_nout : m_n;
        tk  = eval_cond(in_brcond, zf, nf);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_z = 0; m_n = 0; m_brc = 0; m_tkc = 0;
            exp_q.delete();
        end else if (flush) begin
            if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
            m_valid = 0;
        end else begin
            if (drn && exp_q.size() > 0) void'(exp_q.pop_front());
            if (cap) begin
                exp_q.push_back({alu_sum, in_rd, in_regwrite, tk, in_brtarget});
                m_valid = 1;
                if (in_setflags) begin m_z = alu_zout; m_n = alu_nout; end
                if (in_brcond != 3'd0 && m_brc != 16'hFFFF) m_brc++;
                if (tk && m_tkc != 16'hFFFF) m_tkc++;
            end else if (drn) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic z, input logic n,
                         input logic sf, input logic [2:0] c, input logic [31:0] t);
        in_valid = v; alu_sum = s; alu_zout = z; alu_nout = n;
        in_setflags = sf; in_brcond = c; in_brtarget = t;
        in_rd = 5'($urandom_range(0, 31)); in_regwrite = 1'($urandom_range(0, 1));
    endtask

    initial begin
        // reset with in_valid held high
        rst_n = 0; flush = 0; out_ready = 1;
        drive(1, 32'h55, 1, 1, 1, 3'd7, 32'h99);
        m_valid = 0; m_z = 0; m_n = 0; m_brc = 0; m_tkc = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_rd", out_rd, 5'h0);
        chk("rst_br_target", br_target, 32'h0);
        tick();
        rst_n = 1;

        // flag-setting branch on its own zero result
        drive(1, 32'h0, 1, 0, 1, 3'd1, 32'h40); tick();
        drive(0, 32'h0, 0, 0, 0, 3'd0, 32'h0);  tick();
        chk("own_status_z", status_z, 1'b1);

        // held flags: set N, then branch on N without setting flags
        drive(1, 32'hFFFFFFFE, 0, 1, 1, 3'd0, 32'h80); tick();
        drive(1, 32'h0, 1, 0, 0, 3'd3, 32'h84);        tick();
        drive(0, 32'h0, 0, 0, 0, 3'd0, 32'h0);         tick();
        chk("held_status_z", status_z, 1'b0);

        // backpressure for 3 cycles after capturing 0x1234
        drive(1, 32'h1234, 0, 0, 1, 3'd2, 32'h100); tick();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hBAD0 + i, 1, 1, 1, 3'd7, 32'h200); tick();
            chk("stall_sum", out_sum, 32'h1234);
        end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            tick();
            chk("stream_no_bubble", out_valid, 1'b1);
        end

        // clear Z, then flush a Z-setting capture while the slot is full
        drive(1, 32'h7, 0, 0, 1, 3'd1, 32'h300); tick();
        flush = 1;
        drive(1, 32'h0, 1, 0, 1, 3'd1, 32'h304); tick();
        flush = 0;
        drive(0, 32'h0, 0, 0, 0, 3'd0, 32'h0);   tick();
        chk("flush_status_z", status_z, 1'b0);
        chk("flush_br_taken", br_taken, 1'b0);

        // random traffic with occasional flush and backpressure
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            flush     = 1'($urandom_range(0, 9) == 0);
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $urandom);
            tick();
        end
        flush = 0; out_ready = 1;

        // re-reset, then five ~Z branches with Zf = 1,0,1,0,0
        rst_n = 0; drive(0, 32'h0, 0, 0, 0, 3'd0, 32'h0); tick();
        rst_n = 1;
        drive(1, 32'h0, 1, 0, 1, 3'd2, 32'h400); tick();
        drive(1, 32'h1, 0, 0, 1, 3'd2, 32'h404); tick();
        drive(1, 32'h0, 1, 0, 1, 3'd2, 32'h408); tick();
        drive(1, 32'h2, 0, 0, 1, 3'd2, 32'h40C); tick();
        drive(1, 32'h3, 0, 0, 1, 3'd2, 32'h410); tick();
        drive(0, 32'h0, 0, 0, 0, 3'd0, 32'h0);   tick();
        tick();
`ifdef BR_STATS_EN
        chk("stats_br_count", br_count, 16'd5);
        chk("stats_taken_count", br_taken_count, 16'd3);
`endif
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
